// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC sequencer states and the execute-stage opcodes
// that feed the branch/halt decision.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    FLUSH  = 2'd2,
    HALTED = 2'd3
  } pc_state_e;

  localparam logic [4:0] OP_HALT = 5'b11111;
  localparam logic [4:0] OP_BEQ  = 5'b10011;
  localparam logic [4:0] OP_BLT  = 5'b10100;
  localparam logic [4:0] OP_BGT  = 5'b10101;
  localparam logic [4:0] OP_BNE  = 5'b10110;

  function automatic logic is_branch_op(input logic [4:0] op);
    return (op == OP_BEQ) || (op == OP_BLT) || (op == OP_BGT) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter sequencer: boot, sequential fetch, branch redirect with a
// one-cycle squash slot, and a terminal halt state left only through reset.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_0000),
  parameter int              PC_INC   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            pc_branch_sel,
  input  logic [PC_W-1:0] branch_target,
  input  logic            halt,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next_seq,
  output logic            fetch_valid,
  output logic            flush,
  output logic            halted
);

  localparam logic [PC_W-1:0] INC        = PC_W'(PC_INC);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  pc_state_e       state, state_d;
  logic [PC_W-1:0] pc_d;

  assign pc_next_seq = pc + INC;

  always_comb begin
    state_d = state;
    pc_d    = pc;
    case (state)
      BOOT: state_d = RUN;
      RUN: begin
        // halt wins over a simultaneous branch: no redirect, no flush
        if (halt) begin
          state_d = HALTED;
        end else if (pc_branch_sel) begin
          pc_d    = branch_target & ALIGN_MASK;
          state_d = FLUSH;
        end else if (!stall) begin
          pc_d = pc_next_seq;
        end
      end
      FLUSH: begin
        // branch/halt here belong to the squashed instruction
        if (!stall) pc_d = pc_next_seq;
        state_d = RUN;
      end
      HALTED: state_d = HALTED;
      default: state_d = BOOT;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      fetch_valid <= (state_d == RUN);
      flush       <= (state_d == FLUSH);
      halted      <= (state_d == HALTED);
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// against a behavioural PC model.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        pc_branch_sel = 1'b0;
  logic [31:0] branch_target = '0;
  logic        halt = 1'b0;
  logic [31:0] pc, pc_next_seq;
  logic        fetch_valid, flush, halted;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Behavioural model: what the core is doing, not how the RTL encodes it.
  logic [31:0] m_pc;
  bit          m_booting, m_squashing, m_stopped;

  pc_unit #(.PC_W(32), .RESET_PC(32'h0000_0000), .PC_INC(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .pc_branch_sel(pc_branch_sel),
    .branch_target(branch_target),
    .halt         (halt),
    .pc           (pc),
    .pc_next_seq  (pc_next_seq),
    .fetch_valid  (fetch_valid),
    .flush        (flush),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc        = 32'h0;
    m_booting   = 1'b1;
    m_squashing = 1'b0;
    m_stopped   = 1'b0;
  endtask

  task automatic model_edge();
    if (m_stopped) begin
      // frozen until reset
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (m_squashing) begin
      m_squashing = 1'b0;
      if (!stall) m_pc = m_pc + 32'd4;
    end else if (halt) begin
      m_stopped = 1'b1;
    end else if (pc_branch_sel) begin
      m_pc        = {branch_target[31:2], 2'b00};
      m_squashing = 1'b1;
    end else if (!stall) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] exp_seq;
    exp_seq = m_pc + 32'd4;
    check({tag, "_pc"}, pc, m_pc);
    check({tag, "_seq"}, pc_next_seq, exp_seq);
    check({tag, "_fv"}, {31'b0, fetch_valid}, {31'b0, !(m_booting || m_squashing || m_stopped)});
    check({tag, "_flush"}, {31'b0, flush}, {31'b0, m_squashing});
    check({tag, "_halted"}, {31'b0, halted}, {31'b0, m_stopped});
  endtask

  // Drive inputs away from the edge, clock once, compare #1 later.
  task automatic step(input string tag, input logic st, input logic br,
                      input logic [31:0] tgt, input logic hl);
    stall = st; pc_branch_sel = br; branch_target = tgt; halt = hl;
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Assert rst mid-cycle, verify outputs before the next edge, then release.
  task automatic apply_rst(input string tag);
    #2 rst = 1'b1;
    #1;
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_fv"}, {31'b0, fetch_valid}, 32'h0);
    check({tag, "_flush"}, {31'b0, flush}, 32'h0);
    check({tag, "_halted"}, {31'b0, halted}, 32'h0);
    model_reset();
    #1 rst = 1'b0;
    stall = 1'b0; pc_branch_sel = 1'b0; halt = 1'b0;
  endtask

  initial begin
    model_reset();
    #12 rst = 1'b0;
    check("rst_pc", pc, 32'h0);
    check("rst_fv", {31'b0, fetch_valid}, 32'h0);
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);

    // Boot then sequential fetch
    idle("boot");
    check("boot_pc", pc, 32'h0);
    check("boot_fv", {31'b0, fetch_valid}, 32'h1);
    idle("seq1"); check("seq1_pc", pc, 32'h4);
    idle("seq2"); check("seq2_pc", pc, 32'h8);
    idle("seq3"); check("seq3_pc", pc, 32'hC);

    // Branch from pc=8, with a branch+halt pulse arriving during the squash slot
    apply_rst("rst2");
    idle("b_boot"); idle("b_4"); idle("b_8");
    check("b_at8", pc, 32'h8);
    step("br", 1'b0, 1'b1, 32'h0000_0103, 1'b0);
    check("br_pc", pc, 32'h100);
    check("br_flush", {31'b0, flush}, 32'h1);
    check("br_fv", {31'b0, fetch_valid}, 32'h0);
    step("br_fl", 1'b0, 1'b1, 32'h0000_0500, 1'b1);
    check("br_after_pc", pc, 32'h104);
    check("br_after_fv", {31'b0, fetch_valid}, 32'h1);
    check("br_after_flush", {31'b0, flush}, 32'h0);

    // Stall holds pc with fetch_valid still high
    step("s_br", 1'b0, 1'b1, 32'h0000_001C, 1'b0);
    idle("s_fl");
    check("s_at20", pc, 32'h20);
    for (int i = 0; i < 3; i++) begin
      step("stall", 1'b1, 1'b0, 32'h0, 1'b0);
      check("stall_pc", pc, 32'h20);
      check("stall_fv", {31'b0, fetch_valid}, 32'h1);
    end
    idle("unstall");
    check("unstall_pc", pc, 32'h24);

    // Halt together with branch at 0x40
    step("h_br", 1'b0, 1'b1, 32'h0000_003C, 1'b0);
    idle("h_fl");
    check("h_at40", pc, 32'h40);
    step("halt", 1'b0, 1'b1, 32'h0000_0200, 1'b1);
    check("halt_halted", {31'b0, halted}, 32'h1);
    check("halt_pc", pc, 32'h40);
    check("halt_flush", {31'b0, flush}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step("frozen", 1'($urandom()), 1'($urandom()), $urandom(), 1'($urandom()));
      check("frozen_pc", pc, 32'h40);
    end
    apply_rst("rst_halted");

    // Wrap from the top of the address space; branch in FLUSH is ignored
    idle("w_boot");
    step("w_br", 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    step("w_fl", 1'b0, 1'b1, 32'h0000_0700, 1'b0);
    check("w_top", pc, 32'hFFFF_FFFC);
    check("w_top_seq", pc_next_seq, 32'h0);
    idle("wrap");
    check("wrap_pc", pc, 32'h0);

    // Reset in the middle of FLUSH leaves no residual flush
    step("m_br", 1'b0, 1'b1, 32'h0000_0080, 1'b0);
    check("m_flush", {31'b0, flush}, 32'h1);
    apply_rst("rst_flush");
    idle("m_boot");
    check("m_boot_flush", {31'b0, flush}, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        apply_rst("rnd_rst");
      end else begin
        step("rnd",
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0,
             $urandom(),
             $urandom_range(0, 39) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter PC_W, default 32: PC width in bits.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-003 SHALL have parameter PC_INC, default 4: sequential increment, byte-addressed.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  hold the PC this cycle (downstream not ready).
REQ-007 SHALL have port pc_branch_sel  input  1  branch taken, from the branch-decision stage.
REQ-008 SHALL have port branch_target  input  PC_W  redirect address, valid when pc_branch_sel=1.
REQ-009 SHALL have port halt  input  1  decoded HALT instruction in execute.
REQ-010 SHALL have port pc  output  PC_W  current fetch address.
REQ-011 SHALL have port pc_next_seq  output  PC_W  pc+PC_INC, combinational from pc, modulo 2^PC_W.
REQ-012 SHALL have port fetch_valid  output  1  instruction at pc is to be issued.
REQ-013 SHALL have port flush  output  1  squash the younger in-flight instruction.
REQ-014 SHALL have port halted  output  1  core stopped.

Function
REQ-015 SHALL implement 4 states: BOOT, RUN, FLUSH, HALTED; pc, fetch_valid, flush and halted SHALL all be registered.
REQ-016 BOOT SHALL last exactly one cycle after rst deasserts, hold pc, then go to RUN; fetch_valid=0 in BOOT.
REQ-017 RUN SHALL use priority halt > pc_branch_sel > stall > increment.
REQ-018 RUN with halt=1 SHALL hold pc, go to HALTED and set halted=1 from the next cycle.
REQ-019 RUN with pc_branch_sel=1 SHALL load pc <= branch_target with the low 2 bits forced to 0.
REQ-020 In that case it SHALL assert flush for exactly one cycle and go to FLUSH, even if stall=1.
REQ-021 RUN with stall=1 SHALL hold pc; otherwise pc <= pc+PC_INC, wrapping from all-ones-aligned to 0.
REQ-022 FLUSH SHALL last one cycle with fetch_valid=0 and ignore pc_branch_sel and halt, because they come from the squashed instruction.
REQ-023 FLUSH SHALL advance pc by PC_INC unless stall=1, then return to RUN.
REQ-024 HALTED SHALL hold pc and keep fetch_valid=0 and halted=1 until rst; all inputs are ignored.
REQ-025 fetch_valid SHALL be 1 only in RUN; stall SHALL NOT clear fetch_valid.
REQ-026 Simultaneous halt and pc_branch_sel in RUN SHALL resolve to HALTED with no redirect and no flush.

Reset
REQ-027 rst SHALL asynchronously force: state=BOOT, pc=RESET_PC, fetch_valid=0, flush=0, halted=0.
REQ-028 rst asserted in any state, including mid-FLUSH or HALTED, SHALL abandon the operation with no residual flush pulse.

Structure
REQ-029 The state enum, HALT opcode and branch opcodes (BEQ 10011, BLT 10100, BGT 10101, BNE 10110) SHALL live in a shared package cpu_pkg.
REQ-030 The block SHALL be a single module with no sub-module; incrementer and state machine SHALL be inline.

Verification
REQ-031 Release rst with RESET_PC=0 and idle inputs -> the bench SHALL check pc=0 for 2 cycles (fetch_valid=0, then 1), then 4, 8, 12 on successive cycles.
REQ-032 pc=8 in RUN, pc_branch_sel=1 with branch_target=32'h103 -> the bench SHALL check next pc=0x100 and flush=1 for one cycle, then fetch_valid=0 for one cycle, then pc=0x104 with fetch_valid=1.
REQ-033 stall=1 for 3 cycles at pc=0x20 -> the bench SHALL check pc stays 0x20 with fetch_valid=1, then advances to 0x24 when stall drops.
REQ-034 halt=1 together with pc_branch_sel=1 at pc=0x40 -> the bench SHALL check halted=1, pc=0x40 held, no flush pulse, and that pc stays frozen for 10 cycles.
REQ-035 pc=32'hFFFF_FFFC, no stall -> the bench SHALL check next pc=0, and a pc_branch_sel pulse during FLUSH SHALL be ignored.
REQ-036 rst asserted mid-FLUSH and in HALTED -> the bench SHALL check outputs return to reset values asynchronously, before the next clk edge.
